// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin front end that lets N_REQ requesters share one
// fixed-latency FixedPointAdder. Operands are registered onto the adder ports,
// a {valid, index} tag travels alongside the adder latency, and the result is
// handed back, registered, to the requester that issued it.
module adder_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 19,
    parameter int ADD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     GlobalReset,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         add_port1,
    output logic [WIDTH-1:0]         add_port2,
    input  logic [WIDTH-1:0]         add_result,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    output logic [15:0]              done_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Round-robin pointer: the index where the next grant search begins.
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   ptr_nxt_s;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic [IDX_W:0]     cand_s;
    logic               xfer_s;
    logic [N_REQ-1:0]   gnt_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [N_REQ-1:0]   rsp_onehot_s;
    logic               busy_s;

    // Tag pipeline: stage 0 lines up with the adder ports, stage ADD_LAT with add_result.
    logic               tag_vld_r [0:ADD_LAT];
    logic [IDX_W-1:0]   tag_idx_r [0:ADD_LAT];

    // Grant search: first requester at or after ptr_r (wrapping); suppressed by en or reset.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = '0;
        xfer_s    = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = {1'b0, ptr_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!xfer_s && req_valid[cand_s[IDX_W-1:0]]) begin
                xfer_s    = 1'b1;
                gnt_idx_s = cand_s[IDX_W-1:0];
            end else begin
                xfer_s    = xfer_s;
            end
        end
        if (!(en && GlobalReset)) begin
            xfer_s    = 1'b0;
            gnt_idx_s = '0;
        end else begin
            xfer_s    = xfer_s;
        end
        if (xfer_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign req_ready = gnt_s;

    // Operand mux for the granted requester and the pointer value after this grant.
    always_comb begin
        sel_a_s = req_a[gnt_idx_s*WIDTH +: WIDTH];
        sel_b_s = req_b[gnt_idx_s*WIDTH +: WIDTH];
        if (gnt_idx_s == IDX_W'(N_REQ-1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_idx_s + IDX_W'(1);
        end
    end

    // Response owner decode and in-flight indication from the tag pipeline.
    always_comb begin
        rsp_onehot_s = '0;
        busy_s       = 1'b0;
        if (tag_vld_r[ADD_LAT]) begin
            rsp_onehot_s[tag_idx_r[ADD_LAT]] = 1'b1;
        end else begin
            rsp_onehot_s = '0;
        end
        for (int i = 0; i <= ADD_LAT; i++) begin
            busy_s = busy_s | tag_vld_r[i];
        end
    end

    assign busy = busy_s;

    // Pointer advances past the winner only when a transfer actually happens.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Adder operand registers: granted operands for one cycle, zero otherwise.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            add_port1 <= '0;
            add_port2 <= '0;
        end else if (xfer_s) begin
            add_port1 <= sel_a_s;
            add_port2 <= sel_b_s;
        end else begin
            add_port1 <= '0;
            add_port2 <= '0;
        end
    end

    // Tag shift register tracking which requester owns each adder slot.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i <= ADD_LAT; i++) begin
                tag_vld_r[i] <= 1'b0;
                tag_idx_r[i] <= '0;
            end
        end else begin
            tag_vld_r[0] <= xfer_s;
            tag_idx_r[0] <= gnt_idx_s;
            for (int i = 1; i <= ADD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
        end
    end

    // Response registers: capture add_result bit-exact for the tagged owner.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tag_vld_r[ADD_LAT]) begin
            rsp_valid <= rsp_onehot_s;
            rsp_data  <= add_result;
        end else begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end
    end

    // Completion counter, updated together with each response pulse, saturating.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            done_cnt <= 16'h0000;
        end else if (tag_vld_r[ADD_LAT] && (done_cnt != 16'hFFFF)) begin
            done_cnt <= done_cnt + 16'h0001;
        end else begin
            done_cnt <= done_cnt;
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed stimulus for adder_arbiter with a behavioural
// adder, a round-robin reference and a response scoreboard.
module tb_adder_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 19;
    localparam int ADD_LAT = 1;

    logic                   clk;
    logic                   GlobalReset;
    logic                   en;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]       add_port1;
    logic [WIDTH-1:0]       add_port2;
    logic [WIDTH-1:0]       add_result;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic                   busy;
    logic [15:0]            done_cnt;

    adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .en         (en),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_port1  (add_port1),
        .add_port2  (add_port2),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fixed-latency adder.
    logic [WIDTH-1:0] add_pipe [ADD_LAT];
    always @(posedge clk) begin
        add_pipe[0] <= add_port1 + add_port2;
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_result = add_pipe[ADD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard and reference model state.
    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        int               ts;
    } exp_t;
    exp_t             sb_q[$];
    exp_t             e;
    int               m_ptr;
    int               m_done;
    int               m_g;
    int               m_c;
    logic [ADD_LAT:0] hist;
    logic [WIDTH-1:0] nxt_p1;
    logic [WIDTH-1:0] nxt_p2;
    logic [N_REQ-1:0] exp_rdy;
    logic [N_REQ-1:0] exp_rsp;

    // Monitor: compare every output each cycle against the reference.
    always @(negedge clk) begin
        if (!GlobalReset) begin
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            check("rst_rsp_data", 32'(rsp_data), 32'h0);
            check("rst_port1", 32'(add_port1), 32'h0);
            check("rst_port2", 32'(add_port2), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_done_cnt", 32'(done_cnt), 32'h0);
            m_ptr  = 0;
            m_done = 0;
            sb_q.delete();
            hist   = '0;
            nxt_p1 = '0;
            nxt_p2 = '0;
        end else begin
            check("port1", 32'(add_port1), 32'(nxt_p1));
            check("port2", 32'(add_port2), 32'(nxt_p2));
            check("busy", 32'(busy), 32'(|hist));
            if (sb_q.size() > 0 && sb_q[0].ts + 2 + ADD_LAT < cyc) begin
                e = sb_q.pop_front();
                check("rsp_overdue", 32'(cyc), 32'(e.ts + 2 + ADD_LAT));
            end
            if (sb_q.size() > 0 && sb_q[0].ts + 2 + ADD_LAT == cyc) begin
                e = sb_q.pop_front();
                exp_rsp = '0;
                exp_rsp[e.idx] = 1'b1;
                check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                if (m_done < 65535) m_done = m_done + 1;
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
                check("rsp_data_idle", 32'(rsp_data), 32'h0);
            end
            check("done_cnt", 32'(done_cnt), 32'(m_done));
            m_g = -1;
            if (en) begin
                for (int k = 0; k < N_REQ; k++) begin
                    m_c = (m_ptr + k) % N_REQ;
                    if (m_g < 0 && req_valid[m_c]) m_g = m_c;
                end
            end
            exp_rdy = '0;
            if (m_g >= 0) exp_rdy[m_g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            hist = {hist[ADD_LAT-1:0], (m_g >= 0)};
            if (m_g >= 0) begin
                e.idx  = m_g;
                e.data = req_a[m_g*WIDTH +: WIDTH] + req_b[m_g*WIDTH +: WIDTH];
                e.ts   = cyc;
                sb_q.push_back(e);
                nxt_p1 = req_a[m_g*WIDTH +: WIDTH];
                nxt_p2 = req_b[m_g*WIDTH +: WIDTH];
                m_ptr  = (m_g + 1) % N_REQ;
            end else begin
                nxt_p1 = '0;
                nxt_p2 = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    task automatic do_reset();
        GlobalReset = 1'b0;
        req_valid   = '0;
        step();
        step();
        GlobalReset = 1'b1;
        step();
    endtask

    initial begin
        GlobalReset = 1'b0;
        en          = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        step();
        check("reset_done_cnt", 32'(done_cnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        do_reset();

        // Single operation, exact timing.
        set_op(0, 19'h00100, 19'h00200);
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check("single_port1", 32'(add_port1), 32'h00100);
        check("single_port2", 32'(add_port2), 32'h00200);
        check("single_busy", 32'(busy), 32'h1);
        step();
        step();
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_data", 32'(rsp_data), 32'h00300);
        check("single_done_cnt", 32'(done_cnt), 32'h1);
        step();

        // Overflow wraps bit-exact: 0x7FFFF + 0x00002 = 0x00001 in 19 bits.
        set_op(1, 19'h7FFFF, 19'h00002);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        check("wrap_rsp_valid", 32'(rsp_valid), 32'h2);
        check("wrap_rsp_data", 32'(rsp_data), 32'h00001);
        repeat (3) step();

        // All requesters continuously valid after reset: 0,1,2,3,0,...
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            randomize_ops();
            #1;
            check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            step();
        end
        req_valid = '0;
        repeat (5) step();

        // Pointer at 2 with requesters 1 and 3: 3 first, then 1, never 0.
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1010;
        #1;
        check("ptr2_first", 32'(req_ready), 32'h8);
        step();
        check("ptr2_second", 32'(req_ready), 32'h2);
        step();
        check("ptr2_third", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        repeat (5) step();

        // Reset with two operations in flight.
        do_reset();
        randomize_ops();
        req_valid = 4'b0011;
        step();
        step();
        req_valid   = '0;
        GlobalReset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_port1", 32'(add_port1), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        step();
        GlobalReset = 1'b1;
        repeat (6) step();
        check("midrst_done_cnt", 32'(done_cnt), 32'h0);

        // en low blocks grants, in-flight op drains, en high grants immediately.
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0100;
        en        = 1'b0;
        #1;
        check("en0_ready", 32'(req_ready), 32'h0);
        check("en0_busy_inflight", 32'(busy), 32'h1);
        repeat (3) step();
        check("en0_ready_held", 32'(req_ready), 32'h0);
        check("en0_busy_drained", 32'(busy), 32'h0);
        en = 1'b1;
        #1;
        check("en1_grant2", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        repeat (5) step();

        // Saturation of done_cnt after 0xFFFF+ completions.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 65540; k++) begin
            randomize_ops();
            step();
        end
        req_valid = '0;
        repeat (6) step();
        check("sat_done_cnt", 32'(done_cnt), 32'hFFFF);
        repeat (3) step();
        check("sat_done_hold", 32'(done_cnt), 32'hFFFF);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one FixedPointAdder.
REQ-002 Parameter: WIDTH, default 19, operand/result width (signed fixed-point, passed through untouched).
REQ-003 Parameter: ADD_LAT, default 1, fixed cycles from add_port1/add_port2 to a valid add_result (range 1..4).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 GlobalReset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  grant enable; low blocks new grants, in-flight ops complete.
REQ-007 req_valid  input  N_REQ  per-requester operation request.
REQ-008 req_a  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  N_REQ*WIDTH  operand B, same packing.
REQ-010 req_ready  output  N_REQ  one-hot-or-zero grant; transfer when req_valid[i] && req_ready[i].
REQ-011 add_port1  output  WIDTH  registered operand A to adder Port1.
REQ-012 add_port2  output  WIDTH  registered operand B to adder Port2.
REQ-013 add_result  input  WIDTH  adder Output_syn.
REQ-014 rsp_valid  output  N_REQ  one-cycle pulse, one-hot-or-zero, result owner.
REQ-015 rsp_data  output  WIDTH  registered result, valid when any rsp_valid bit set.
REQ-016 busy  output  1  high while any operation is in flight.
REQ-017 done_cnt  output  16  count of completed operations, saturating at 0xFFFF.

Function
REQ-018 Arbitration: round-robin; search starts at index ptr, wraps N_REQ-1 -> 0; first req_valid found is granted.
REQ-019 req_ready is combinational from req_valid, ptr, en; at most one bit high; all zero when en=0 or no req_valid.
REQ-020 On a transfer by requester g, ptr SHALL update to (g+1) mod N_REQ next cycle; no transfer leaves ptr unchanged.
REQ-021 At most one transfer per cycle; fully pipelined, back-to-back transfers every cycle allowed.
REQ-022 Transfer in cycle t: add_port1/add_port2 = req_a/req_b of g in cycle t+1; cycles with no transfer drive 0 on both.
REQ-023 Tag pipeline of depth 1+ADD_LAT carries {valid, index}; add_result is sampled in cycle t+1+ADD_LAT.
REQ-024 rsp_valid[g] SHALL pulse and rsp_data = sampled add_result in cycle t+2+ADD_LAT (3 cycles for default ADD_LAT=1); rsp_data=0 when no pulse.
REQ-025 Responses have no backpressure; order of responses equals order of transfers.
REQ-026 done_cnt increments by 1 on every rsp_valid pulse, holds at 0xFFFF.
REQ-027 busy = OR of tag-pipeline valid bits (registered state only, not current-cycle transfer).
REQ-028 en deasserted mid-stream: no new grants from that cycle; already transferred ops still respond per REQ-024.
REQ-029 req_valid dropped without transfer: no effect on ptr or pipeline.
REQ-030 Arithmetic overflow is the adder's concern; rsp_data passes add_result bit-exact.

Reset
REQ-031 GlobalReset low asynchronously clears: ptr=0, tag pipeline, add_port1/2=0, rsp_valid=0, rsp_data=0, done_cnt=0, busy=0; req_ready=0 while reset asserted.
REQ-032 Reset mid-operation discards in-flight ops; no rsp_valid for them after release.
REQ-033 First grant after release SHALL go to lowest-index requesting port (ptr=0).

Verification
REQ-034 Single op: req 0, a=0x00100, b=0x00200, ADD_LAT=1 -> ready[0] same cycle, ports 0x00100/0x00200 at t+1, rsp_valid=0001, rsp_data=0x00300 at t+3, done_cnt=1.
REQ-035 All 4 requesters valid continuously after reset -> grants 0,1,2,3,0,... one per cycle; responses in same order, 3-cycle latency each.
REQ-036 Req 1 and 3 valid, ptr=2 -> requester 3 granted first, then 1; req 0 idle never granted.
REQ-037 Reset asserted with 2 ops in flight -> outputs zero immediately; after release no rsp_valid pulses, done_cnt=0.
REQ-038 en=0 while req 2 valid -> req_ready stays 0, busy falls after in-flight drain; en=1 -> grant 2 that cycle.
REQ-039 Force done_cnt to 0xFFFE, complete 3 ops -> done_cnt = 0xFFFF and holds.
